// File: rtl/reg_file_dump_pkg.sv
// Shared definitions for the register-file dump engine: FSM state encoding,
// default geometry and a helper that maps an entry index to an ECR select.
package reg_file_dump_pkg;

  // FSM state type and encodings
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ISSUE   = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_SEND    = 3'd3;
  localparam state_t ST_FIN     = 3'd4;

  // Default geometry
  localparam int DEF_NUM_GPR = 32;
  localparam int DEF_NUM_ECR = 6;
  localparam int DEF_DATA_W  = 34;
  localparam int LAST_IDX    = DEF_NUM_GPR + DEF_NUM_ECR - 1;

  // Fixed field widths of the register-file and output interfaces
  localparam int GPR_W  = 32;
  localparam int GPR_AW = 5;
  localparam int ECR_SW = 3;
  localparam int IDX_W  = 6;

  // ECR select for an entry index; indices below the GPR range map to 0
  // instead of underflowing.
  function automatic logic [ECR_SW-1:0] ecr_sel_of(input logic [IDX_W-1:0] i,
                                                   input logic [IDX_W-1:0] num_gpr);
    logic [IDX_W-1:0] d;
    d = (i >= num_gpr) ? (i - num_gpr) : '0;
    return ECR_SW'(d);
  endfunction

endpackage

// File: rtl/reg_file_dump_out_reg.sv
// Output register slice of the dump engine: holds the word presented to the
// consumer so it stays stable for as long as the consumer stalls.
module dump_out_reg #(
  parameter int DATA_W = 34,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              load,
  input  logic              clr_last,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_index,
  input  logic              in_last,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last
);

  // Capture a new word on load; a cancelled dump drops the last flag so a
  // later dump never starts with a stale end marker.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= in_data;
      out_index <= in_index;
      out_last  <= in_last;
    end else if (clr_last) begin
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_dump.sv
// Register-file dump engine: walks every GPR then every ECR, reads each one
// through a one-cycle-latency read port and streams it out on a
// valid/ready interface as (index, value, last). Three cycles per entry.
module reg_file_dump
  import reg_file_dump_pkg::*;
#(
  parameter int NUM_GPR = DEF_NUM_GPR,
  parameter int NUM_ECR = DEF_NUM_ECR,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [4:0]        gpr_rd_addr,
  input  logic [31:0]       gpr_rd_data,
  output logic [2:0]        ecr_rd_sel,
  input  logic [DATA_W-1:0] ecr_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam logic [IDX_W-1:0] GPR_CNT = IDX_W'(NUM_GPR);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_GPR + NUM_ECR - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  load_idx;
  logic              cancel;
  logic              accept;
  logic              go_issue;
  logic              capture;
  logic [DATA_W-1:0] cap_data;

  // Abort only matters once a dump is running; in IDLE it merely blocks start.
  assign cancel   = abort && (state != ST_IDLE);
  assign accept   = (state == ST_SEND) && out_ready && !abort;
  assign go_issue = ((state == ST_IDLE) && start && !abort) || (accept && !out_last);
  assign load_idx = (state == ST_IDLE) ? '0 : idx + IDX_W'(1);
  assign capture  = (state == ST_CAPTURE) && !abort;
  assign cap_data = (idx < GPR_CNT) ? DATA_W'(gpr_rd_data) : ecr_rd_data;

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign out_valid = (state == ST_SEND);

  // Main sequencer: IDLE -> (ISSUE -> CAPTURE -> SEND)* -> FIN -> IDLE.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else if (cancel) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go_issue) begin
            state <= ST_ISSUE;
            idx   <= '0;
          end
        end
        ST_ISSUE:   state <= ST_CAPTURE;
        ST_CAPTURE: state <= ST_SEND;
        ST_SEND: begin
          if (accept) begin
            if (out_last) begin
              state <= ST_FIN;
            end else begin
              state <= ST_ISSUE;
              idx   <= load_idx;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read addresses are loaded on entry to ISSUE so the register file sees
  // them during ISSUE and returns data in CAPTURE; otherwise they hold.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      gpr_rd_addr <= '0;
      ecr_rd_sel  <= '0;
    end else if (go_issue) begin
      if (load_idx < GPR_CNT) begin
        gpr_rd_addr <= load_idx[GPR_AW-1:0];
      end else begin
        ecr_rd_sel  <= ecr_sel_of(load_idx, GPR_CNT);
      end
    end
  end

  dump_out_reg #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_out_reg (
    .clk       (clk),
    .rstb      (rstb),
    .load      (capture),
    .clr_last  (cancel),
    .in_data   (cap_data),
    .in_index  (idx),
    .in_last   (idx == LAST),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

endmodule

// File: doc/reg_file_dump.md
REG_FILE_DUMP -- requirements
Module: reg_file_dump

Interface
Parameters:
REQ-001 The block SHALL have parameter NUM_GPR, default 32, meaning the number of general-purpose registers dumped.
REQ-002 The block SHALL have parameter NUM_ECR, default 6, meaning the number of edge-collision registers dumped after the general-purpose registers.
REQ-003 The block SHALL have parameter DATA_W, default 34, meaning the output word width; general-purpose values (32 bits) are zero-extended to it.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rstb, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request a full dump; sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1 bit: cancel a dump in progress.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last word is accepted.
REQ-010 The block SHALL have port gpr_rd_addr, output, 5 bits: read address to the general-purpose register file.
REQ-011 The block SHALL have port gpr_rd_data, input, 32 bits: read data, valid exactly one cycle after gpr_rd_addr.
REQ-012 The block SHALL have port ecr_rd_sel, output, 3 bits: edge-collision register select.
REQ-013 The block SHALL have port ecr_rd_data, input, DATA_W bits: read data, valid exactly one cycle after ecr_rd_sel.
REQ-014 The block SHALL have port out_valid, output, 1 bit: the output word is valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-016 The block SHALL have port out_index, output, 6 bits: entry index, 0..NUM_GPR+NUM_ECR-1.
REQ-017 The block SHALL have port out_data, output, DATA_W bits: entry value.
REQ-018 The block SHALL have port out_last, output, 1 bit: high with the final entry (index 37 at defaults).

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, CAPTURE, SEND and FIN, encoded in the shared package.
REQ-020 IDLE SHALL go to ISSUE when start=1, clearing the entry counter idx to 0; start in any other state SHALL be ignored.
REQ-021 ISSUE SHALL drive gpr_rd_addr=idx[4:0] when idx<NUM_GPR, otherwise ecr_rd_sel=idx-NUM_GPR, then go to CAPTURE.
REQ-022 CAPTURE SHALL register the selected read data into out_data, idx into out_index, and (idx==NUM_GPR+NUM_ECR-1) into out_last, then go to SEND.
REQ-023 SEND SHALL hold out_valid=1 with out_data, out_index and out_last stable until out_valid&&out_ready.
REQ-024 On acceptance in SEND, the FSM SHALL go to FIN if out_last=1, otherwise increment idx and go to ISSUE.
REQ-025 out_valid SHALL be 1 only in SEND.
REQ-026 FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-027 Address outputs SHALL hold their last value outside ISSUE and CAPTURE.
REQ-028 Latency SHALL be 3 cycles from start to the first out_valid.
REQ-029 Throughput SHALL be one entry per 3 cycles when out_ready is held high, so a full dump takes 3*38 cycles plus the FIN cycle.
REQ-030 Backpressure SHALL be unbounded with no data loss or reordering; out_ready while out_valid=0 SHALL be ignored.
REQ-031 abort=1 in any non-IDLE state SHALL return the FSM to IDLE next cycle, with out_valid=0, no done pulse, and no partial out_last.
REQ-032 abort takes priority over a simultaneous handshake; the word is treated as not delivered.
REQ-033 abort and start high together in IDLE SHALL be resolved with abort winning: stay in IDLE.
REQ-034 idx SHALL never exceed NUM_GPR+NUM_ECR-1 and SHALL never wrap; the ECR select SHALL be computed without underflow.

Reset
REQ-035 Asserting rstb SHALL immediately force state=IDLE, idx=0, busy=0, done=0, out_valid=0, out_last=0, out_index=0, out_data=0, gpr_rd_addr=0 and ecr_rd_sel=0.
REQ-036 Reset asserted mid-dump SHALL drop out_valid asynchronously; the first start after deassertion SHALL begin again at index 0.

Structure
REQ-037 Shared package SHALL hold the FSM state typedef, NUM_GPR/NUM_ECR/DATA_W defaults, and the LAST_IDX constant (37).
REQ-038 No sub-module is required; the output register slice MAY be factored as a sub-module named dump_out_reg.

Verification
REQ-039 With GPR x1=0x0000_0001 and x31=0xDEAD_BEEF, ECR e0=0x3_FFFF_FFFF and e5=0x1_2345_6789, start and out_ready=1 SHALL yield 38 words, index 0..37, with out_data[1]=0x0_0000_0001, out_data[31]=0x0_DEAD_BEEF, out_data[32]=0x3_FFFF_FFFF, out_data[37]=0x1_2345_6789, out_last only at index 37, and done 1 cycle after the last acceptance.
REQ-040 With out_ready low for 20 cycles at index 5 SHALL hold out_valid, out_index=5 and out_data stable, with no skipped or duplicate index.
REQ-041 With a start pulse at indices 10 and 30 mid-dump SHALL produce no restart and exactly 38 words.
REQ-042 With abort at index 33 coincident with out_ready SHALL give out_valid=0 and busy=0 next cycle and no done; a following start SHALL restart at index 0.
REQ-043 With rstb asserted asynchronously at index 20 between clock edges SHALL drop outputs immediately to reset values; after release, IDLE SHALL hold until start.
REQ-044 With random out_ready (50%) over 100 dumps SHALL give in-order indices and data matching the register-file model, with a 1:1 ratio of done pulses to completed dumps.
